// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits + odd parity + stop
// shifted out on device clock falls, then ACK check. Pin drives are open-collector enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2k_clk_in,
  input  logic       ps2k_data_in,
  input  logic [7:0] tx_byte,
  input  logic       tx_start,
  output logic       ps2k_clk_oe,
  output logic       ps2k_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int IW = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_STOP, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state;
  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;   // data is only ever read from the second stage
  logic [8:0]    shift;
  logic [3:0]    bitcnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;

  logic clk_r1, clk_r2, data_r1, fall, running, timeout;

  assign clk_r1  = clk_sync[1];
  assign clk_r2  = clk_sync[2];
  assign data_r1 = data_sync[1];
  assign fall    = ~clk_r1 & clk_r2;
  assign running = (state == S_SEND) || (state == S_STOP) ||
                   (state == S_ACK)  || (state == S_WAIT_IDLE);
  assign timeout = running && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      clk_sync     <= 3'b111;
      data_sync    <= 2'b11;
      shift        <= '0;
      bitcnt       <= '0;
      inh_cnt      <= '0;
      to_cnt       <= '0;
      ps2k_clk_oe  <= 1'b0;
      ps2k_data_oe <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2k_clk_in};
      data_sync <= {data_sync[0], ps2k_data_in};
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
      if (running) to_cnt <= to_cnt + 1'b1;

      if (timeout) begin
        ps2k_clk_oe  <= 1'b0;
        ps2k_data_oe <= 1'b0;
        tx_err       <= 1'b1;
        tx_busy      <= 1'b0;
        state        <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (tx_start) begin
              shift       <= {~^tx_byte, tx_byte};
              bitcnt      <= '0;
              inh_cnt     <= '0;
              to_cnt      <= '0;
              ps2k_clk_oe <= 1'b1;
              tx_busy     <= 1'b1;
              state       <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            // clk_oe rose on the accept edge, so the last inhibit cycle is the RTS cycle
            if (inh_cnt == IW'(INHIBIT_CYCLES - 2)) begin
              ps2k_data_oe <= 1'b1;
              state        <= S_RTS;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          S_RTS: begin
            ps2k_clk_oe <= 1'b0;
            to_cnt      <= '0;
            bitcnt      <= '0;
            state       <= S_SEND;
          end
          S_SEND: begin
            if (fall) begin
              ps2k_data_oe <= ~shift[bitcnt];
              bitcnt       <= bitcnt + 1'b1;
              if (bitcnt == 4'd8) state <= S_STOP;
            end
          end
          S_STOP: begin
            if (fall) begin
              ps2k_data_oe <= 1'b0;
              state        <= S_ACK;
            end
          end
          S_ACK: begin
            if (fall) begin
              if (!data_r1) begin
                state <= S_WAIT_IDLE;
              end else begin
                ps2k_clk_oe  <= 1'b0;
                ps2k_data_oe <= 1'b0;
                tx_err       <= 1'b1;
                tx_busy      <= 1'b0;
                state        <= S_IDLE;
              end
            end
          end
          S_WAIT_IDLE: begin
            if (clk_r1 && data_r1) begin
              tx_done <= 1'b1;
              tx_busy <= 1'b0;
              state   <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
